// File: rtl/pwm_audio_dac_pkg.sv
// Shared constants for the PWM audio DAC slice: gain fraction bits, underrun counter width,
// and the midscale duty helper.
package pwm_audio_dac_pkg;

    localparam int unsigned GAIN_FRAC = 3;
    localparam int unsigned UCNT_W    = 16;

    function automatic int unsigned midscale(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/pwm_audio_dac_if.sv
// Sample stream handshake between the sine generator and the PWM DAC.
interface pwm_audio_dac_if #(
    parameter int unsigned DATA_W = 8
);

    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);

endinterface

// File: rtl/pwm_audio_dac_gain_sat.sv
// audio_gain_sat: combinational signed sample x unsigned gain, arithmetic shift by GAIN_FRAC,
// clamp to the signed DATA_W range.
module audio_gain_sat
    import pwm_audio_dac_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned GAIN_W = 4
) (
    input  logic [DATA_W-1:0] din,
    input  logic [GAIN_W-1:0] gain,
    output logic [DATA_W-1:0] dout
);

    localparam int unsigned PROD_W = DATA_W + GAIN_W + 1;

    localparam logic signed [PROD_W-1:0] SAT_MAX = {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN = {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [PROD_W-1:0] din_x;
    logic signed [PROD_W-1:0] gain_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shr;

    always_comb begin
        din_x  = {{(PROD_W-DATA_W){din[DATA_W-1]}}, din};
        gain_x = {{(PROD_W-GAIN_W){1'b0}}, gain};
        prod   = din_x * gain_x;
        // >>> on a signed operand rounds toward -inf
        shr    = prod >>> GAIN_FRAC;
        if (shr > SAT_MAX) begin
            dout = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (shr < SAT_MIN) begin
            dout = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            dout = shr[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/pwm_audio_dac.sv
// PWM audio DAC: one-entry sample buffer, gain/saturate, offset-binary duty, PWM carrier.
// Optional `PWM_UNDERRUN_CNT_EN adds the saturating underrun_cnt output.
module pwm_audio_dac
    import pwm_audio_dac_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PWM_W  = 8,
    parameter int unsigned GAIN_W = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    pwm_audio_dac_if.slave    s,
    input  logic [GAIN_W-1:0] gain,
    input  logic              enable,
    output logic              pwm_out,
    output logic              frame_start,
    output logic              underrun
`ifdef PWM_UNDERRUN_CNT_EN
    ,
    output logic [UCNT_W-1:0] underrun_cnt
`endif
);

    localparam logic [PWM_W-1:0] DUTY_MID = PWM_W'(midscale(PWM_W));

    logic [PWM_W-1:0]  cnt;
    logic [PWM_W-1:0]  duty;
    logic [PWM_W-1:0]  duty_load;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] gained;
    logic              hold_full;
    logic              capture;
    logic              load;

    audio_gain_sat #(
        .DATA_W (DATA_W),
        .GAIN_W (GAIN_W)
    ) u_gain_sat (
        .din  (s.data),
        .gain (gain),
        .dout (gained)
    );

    always_comb begin
        s.ready   = !hold_full;
        capture   = s.valid && !hold_full;
        load      = enable && (cnt == '1);
        duty_load = PWM_W'({~hold[DATA_W-1], hold[DATA_W-2:0]}) << (PWM_W - DATA_W);
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            cnt         <= '0;
            duty        <= DUTY_MID;
            hold        <= '0;
            hold_full   <= 1'b0;
            pwm_out     <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            cnt         <= enable ? cnt + PWM_W'(1) : '0;
            pwm_out     <= enable && (cnt < duty);
            frame_start <= load;
            underrun    <= load && !hold_full;
            if (capture) begin
                hold <= gained;
            end
            // a capture wins over the load's clear so a sample arriving at the frame edge is kept
            if (capture) begin
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            if (load && hold_full) begin
                duty <= duty_load;
            end
        end
    end

`ifdef PWM_UNDERRUN_CNT_EN
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            underrun_cnt <= '0;
        end else if (underrun && (underrun_cnt != '1)) begin
            underrun_cnt <= underrun_cnt + UCNT_W'(1);
        end
    end
`endif

endmodule
